// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl
//   Sequences the E-stage multiply/divide unit and owns the HI/LO registers.
//   Accepts one mult/div/mthi/mtlo operation per cycle. Multi-cycle latency is
//   modelled with a busy counter. The result is computed at issue and committed
//   to HI/LO on the edge where the counter expires.
//
//   Optional feature: define MD_MADD_EN to accept MADD/MADDU/MSUB/MSUBU (ops 7-10).
//   Without it, those op codes behave as NONE.
//
// Ports
//   clk       in   1   system clock, rising edge
//   reset     in   1   synchronous, active-high
//   E_md_op   in   4   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//                      7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; others are NONE
//   E_rs_val  in   32  forwarded rs operand
//   E_rt_val  in   32  forwarded rt operand
//   D_md_use  in   1   instruction in D uses the md unit or HI/LO
//   busy      out  1   operation in flight
//   hi        out  32  HI register
//   lo        out  32  LO register
//   md_stall  out  1   stall request for D
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        D_md_use,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        commit_q, commit_d;

  // Op decode
  logic is_mul, is_div, is_acc, is_sub, is_signed, is_long;

  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_acc    = 1'b0;
    is_sub    = 1'b0;
    is_signed = 1'b0;
    case (E_md_op)
      4'd1: begin is_mul = 1'b1; is_signed = 1'b1; end
      4'd2: is_mul = 1'b1;
      4'd3: begin is_div = 1'b1; is_signed = 1'b1; end
      4'd4: is_div = 1'b1;
`ifdef MD_MADD_EN
      4'd7:  begin is_mul = 1'b1; is_acc = 1'b1; is_signed = 1'b1; end
      4'd8:  begin is_mul = 1'b1; is_acc = 1'b1; end
      4'd9:  begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; is_signed = 1'b1; end
      4'd10: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
      default: ;
    endcase
    is_long = is_mul | is_div;
  end

  // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the product
  // are then correct for both signed and unsigned operands.
  logic [63:0] mul_a, mul_b, prod, acc;

  always_comb begin
    mul_a = is_signed ? {{32{E_rs_val[31]}}, E_rs_val} : {32'b0, E_rs_val};
    mul_b = is_signed ? {{32{E_rt_val[31]}}, E_rt_val} : {32'b0, E_rt_val};
    prod  = mul_a * mul_b;
    acc   = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
  end

  // Divide: signed case runs on magnitudes, then quotient takes the XOR of the
  // signs and the remainder takes the dividend's sign (truncation toward zero).
  logic        div_zero, neg_a, neg_b;
  logic [31:0] abs_a, abs_b, dsor, q_mag, r_mag, quo, rem;

  always_comb begin
    div_zero = (E_rt_val == '0);
    neg_a    = is_signed & E_rs_val[31];
    neg_b    = is_signed & E_rt_val[31];
    abs_a    = neg_a ? (~E_rs_val + 32'd1) : E_rs_val;
    abs_b    = neg_b ? (~E_rt_val + 32'd1) : E_rt_val;
    dsor     = div_zero ? 32'd1 : abs_b;
    q_mag    = abs_a / dsor;
    r_mag    = abs_a % dsor;
    quo      = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    rem      = neg_a ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    commit_d = commit_q;
    case (state_q)
      IDLE: begin
        if (is_long) begin
          state_d = BUSY;
          busy_d  = 1'b1;
          if (is_div) begin
            cnt_d    = 4'(DIV_CYCLES - 1);
            res_hi_d = rem;
            res_lo_d = quo;
            commit_d = ~div_zero;
          end else begin
            cnt_d    = 4'(MULT_CYCLES - 1);
            {res_hi_d, res_lo_d} = is_acc ? acc : prod;
            commit_d = 1'b1;
          end
        end else if (E_md_op == 4'd5) begin
          hi_d = E_rs_val;
        end else if (E_md_op == 4'd6) begin
          lo_d = E_rs_val;
        end
      end
      BUSY: begin
        // Any op arriving here is ignored.
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (commit_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      commit_q <= 1'b0;
    end else begin
      if (state_q == BUSY && is_long)
        $warning("md_unit_ctrl: op %0d issued while busy, ignored", E_md_op);
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      commit_q <= commit_d;
    end
  end

  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_stall = D_md_use & (busy_q | is_long);

endmodule

// File: tb/tb_md_unit_ctrl.sv
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_md_op;
  logic [31:0] E_rs_val, E_rt_val;
  logic        D_md_use;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MD_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_md_op(E_md_op), .E_rs_val(E_rs_val),
    .E_rt_val(E_rt_val), .D_md_use(D_md_use), .busy(busy), .hi(hi), .lo(lo),
    .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_left = 0;      // busy cycles remaining
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  bit          m_ok = 1'b0;

  function automatic bit long_op(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd4) || (MADD && op >= 4'd7 && op <= 4'd10);
  endfunction

  always @(posedge clk) begin
    logic [63:0] p;
    int sa, sb;
    if (reset) begin
      m_left = 0; m_hi = '0; m_lo = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_ok) {m_hi, m_lo} = m_pend;
    end else begin
      sa = E_rs_val; sb = E_rt_val;
      m_ok = 1'b1;
      case (E_md_op)
        4'd1, 4'd7, 4'd9: p = longint'(sa) * longint'(sb);
        default:          p = {32'b0, E_rs_val} * {32'b0, E_rt_val};
      endcase
      case (E_md_op)
        4'd1, 4'd2: begin m_pend = p; m_left = 5; end
        4'd3: begin
          m_ok = (sb != 0);
          if (m_ok) m_pend = {32'(sa % sb), 32'(sa / sb)};
          m_left = 10;
        end
        4'd4: begin
          m_ok = (E_rt_val != 0);
          if (m_ok) m_pend = {E_rs_val % E_rt_val, E_rs_val / E_rt_val};
          m_left = 10;
        end
        4'd5: m_hi = E_rs_val;
        4'd6: m_lo = E_rs_val;
        4'd7, 4'd8: if (MADD) begin m_pend = {m_hi, m_lo} + p; m_left = 5; end
        4'd9, 4'd10: if (MADD) begin m_pend = {m_hi, m_lo} - p; m_left = 5; end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("m_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
      chk("m_hi", hi, m_hi);
      chk("m_lo", lo, m_lo);
      chk("m_stall", {31'b0, md_stall},
          {31'b0, D_md_use && (m_left > 0 || long_op(E_md_op))});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic use_d, input logic exp_stall, input int exp_len);
    int n;
    E_md_op = op; E_rs_val = a; E_rt_val = b; D_md_use = use_d;
    #1 chk("issue_stall", {31'b0, md_stall}, {31'b0, exp_stall});
    @(posedge clk); #1;
    E_md_op = 4'd0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("busy_len", n, exp_len);
    D_md_use = 1'b0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    E_md_op = op; E_rs_val = v;
    @(posedge clk); #1;
    E_md_op = 4'd0;
    chk("mt_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; E_md_op = '0; E_rs_val = '0; E_rt_val = '0; D_md_use = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'b0, md_stall}, 32'd0);

    // 1. signed multiply, stall during issue and busy
    run(4'd1, 32'd3, 32'hFFFF_FFFE, 1'b1, 1'b1, 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // 2. divides
    run(4'd4, 32'd7, 32'd2, 1'b0, 1'b0, 10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    run(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 10);
    chk("divneg_lo", lo, 32'hFFFF_FFFD);
    chk("divneg_hi", hi, 32'd1);

    // 3. unsigned multiply without D use; MTHI while busy is ignored
    run(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 5);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    E_md_op = 4'd2; E_rs_val = 32'd2; E_rt_val = 32'd3;
    @(posedge clk); #1;
    E_md_op = 4'd5; E_rs_val = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    E_md_op = 4'd15;                        // unused code acts as NONE
    @(posedge clk); #1;
    E_md_op = 4'd0;
    repeat (4) @(posedge clk); #1;
    chk("mthi_busy_hi", hi, 32'd0);
    chk("mthi_busy_lo", lo, 32'd6);

    // 4. MTHI/MTLO then divide by zero
    mt(4'd5, 32'h1234);
    chk("mthi_hi", hi, 32'h1234);
    mt(4'd6, 32'h5678);
    chk("mtlo_lo", lo, 32'h5678);
    run(4'd3, 32'd99, 32'd0, 1'b1, 1'b1, 10);
    chk("dz_hi", hi, 32'h1234);
    chk("dz_lo", lo, 32'h5678);

    // 5. reset in third busy cycle of a DIV
    E_md_op = 4'd3; E_rs_val = 32'd100; E_rt_val = 32'd7;
    @(posedge clk); #1;
    E_md_op = 4'd0;
    repeat (2) @(posedge clk); #1;
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    repeat (15) @(posedge clk); #1;
    chk("no_commit_hi", hi, 32'd0);
    chk("no_commit_lo", lo, 32'd0);

    // 6. MADDU carry into HI (or ignored when the feature is absent)
    mt(4'd5, 32'd0);
    mt(4'd6, 32'hFFFF_FFFF);
`ifdef MD_MADD_EN
    run(4'd8, 32'd1, 32'd1, 1'b1, 1'b1, 5);
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
    run(4'd9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 5);  // {1,0} - (-2) = {1,2}
    chk("msub_hi", hi, 32'd1);
    chk("msub_lo", lo, 32'd2);
`else
    run(4'd8, 32'd1, 32'd1, 1'b1, 1'b0, 0);
    chk("maddu_off_hi", hi, 32'd0);
    chk("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

    repeat (2) @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
